// File: rtl/lfsr_word_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_pkg
// Brief    : Shared types and constants for the LFSR word scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package lfsr_pkg;

    localparam int LFSR_WIDTH = 28;
    localparam int TAP_A      = 27;
    localparam int TAP_B      = 24;

    localparam logic [LFSR_WIDTH-1:0] DEFAULT_SEED = 28'hACE1234;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEED    = 2'd1,
        GATHER  = 2'd2,
        DELIVER = 2'd3
    } sched_state_t;

endpackage : lfsr_pkg
`default_nettype wire

// File: rtl/lfsr_word_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_word_sched_if
// Brief    : Request/grant/word bus between random-number consumers and the
//            shared LFSR scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface lfsr_word_sched_if
    import lfsr_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int W     = 8
);
    logic [LFSR_WIDTH-1:0] seed_i;
    logic                  seed_load;
    logic [N_REQ-1:0]      req;
    logic [N_REQ-1:0]      gnt;
    logic                  ack;
    logic [W-1:0]          word_data;
    logic                  busy;

    modport master (
        output seed_i, seed_load, req,
        input  gnt, ack, word_data, busy
    );

    modport slave (
        input  seed_i, seed_load, req,
        output gnt, ack, word_data, busy
    );

endinterface : lfsr_word_sched_if
`default_nettype wire

// File: rtl/lfsr_word_sched_lfsr_fib28.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_fib28
// Brief    : 28-bit Fibonacci LFSR, x^28+x^25+1, serial output from the MSB.
// Revision : 1.0 - initial release
// ============================================================================
module lfsr_fib28
    import lfsr_pkg::*;
#(
    parameter logic [LFSR_WIDTH-1:0] RESET_VAL = lfsr_pkg::DEFAULT_SEED
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  load,
    input  logic [LFSR_WIDTH-1:0] load_val,
    output logic                  r
);

    logic [LFSR_WIDTH-1:0] r_state;
    logic                  w_fb;

    assign w_fb = r_state[TAP_A] ^ r_state[TAP_B];
    assign r    = r_state[TAP_A];

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= RESET_VAL;
        end else if (load) begin
            r_state <= load_val;
        end else if (en) begin
            r_state <= {r_state[LFSR_WIDTH-2:0], w_fb};
        end
    end

endmodule : lfsr_fib28
`default_nettype wire

// File: rtl/lfsr_word_sched.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_word_sched
// Brief    : Round-robin shares one 28-bit LFSR between N_REQ requesters,
//            assembling W serial bits into a word and sequencing reseeds.
// Revision : 1.0 - initial release
// ============================================================================
module lfsr_word_sched
    import lfsr_pkg::*;
#(
    parameter int                    N_REQ        = 4,
    parameter int                    W            = 8,
    parameter logic [LFSR_WIDTH-1:0] DEFAULT_SEED = lfsr_pkg::DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              reset,
    lfsr_word_sched_if.slave  bus
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(W + 1);

    sched_state_t          r_state;
    sched_state_t          w_state_next;

    logic [IDX_W-1:0]      r_ptr;
    logic [IDX_W-1:0]      r_gidx;
    logic [N_REQ-1:0]      r_gnt;
    logic [CNT_W-1:0]      r_cnt;
    logic [W-1:0]          r_word;
    logic [W-1:0]          r_word_data;
    logic                  r_ack;
    logic [LFSR_WIDTH-1:0] r_seed_reg;
    logic                  r_seed_pend;

    logic                  w_bit;
    logic                  w_found;
    logic [IDX_W-1:0]      w_pick;
    logic [W-1:0]          w_word_next;
    logic                  w_last;
    logic [LFSR_WIDTH-1:0] w_seed_eff;

    function automatic logic [IDX_W-1:0] rr_index(input logic [IDX_W-1:0] base, input int off);
        int j;
        j = int'(base) + off;
        if (j >= N_REQ) begin
            j = j - N_REQ;
        end
        return IDX_W'(j);
    endfunction

    // A zero seed would lock the LFSR at zero forever.
    assign w_seed_eff = (r_seed_reg == '0) ? DEFAULT_SEED : r_seed_reg;

    lfsr_fib28 #(
        .RESET_VAL (DEFAULT_SEED)
    ) u_lfsr (
        .clk      (clk),
        .reset    (reset),
        .en       (r_state == GATHER),
        .load     (r_state == SEED),
        .load_val (w_seed_eff),
        .r        (w_bit)
    );

    assign w_word_next = W'({r_word, w_bit});
    assign w_last      = (r_cnt == CNT_W'(W - 1));

    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!w_found && bus.req[rr_index(r_ptr, i)]) begin
                w_found = 1'b1;
                w_pick  = rr_index(r_ptr, i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (r_seed_pend) begin
                    w_state_next = SEED;
                end else if (w_found) begin
                    w_state_next = GATHER;
                end
            end
            SEED:    w_state_next = IDLE;
            GATHER:  if (w_last) w_state_next = DELIVER;
            DELIVER: w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ptr       <= '0;
            r_gidx      <= '0;
            r_gnt       <= '0;
            r_cnt       <= '0;
            r_word      <= '0;
            r_word_data <= '0;
            r_ack       <= 1'b0;
            r_seed_reg  <= '0;
            r_seed_pend <= 1'b0;
        end else begin
            // A fresh pulse arriving while SEED applies the old value stays pending.
            if (bus.seed_load) begin
                r_seed_reg  <= bus.seed_i;
                r_seed_pend <= 1'b1;
            end else if (r_state == SEED) begin
                r_seed_pend <= 1'b0;
            end

            r_ack <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!r_seed_pend && w_found) begin
                        r_gnt  <= N_REQ'(1) << w_pick;
                        r_gidx <= w_pick;
                        r_cnt  <= '0;
                    end
                end
                GATHER: begin
                    r_word <= w_word_next;
                    r_cnt  <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_word_data <= w_word_next;
                        r_ack       <= 1'b1;
                    end
                end
                DELIVER: begin
                    r_gnt <= '0;
                    r_ptr <= (r_gidx == IDX_W'(N_REQ - 1)) ? '0 : r_gidx + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.ack       = r_ack;
    assign bus.word_data = r_word_data;
    assign bus.busy      = (r_state != IDLE) || r_seed_pend;

endmodule : lfsr_word_sched
`default_nettype wire

// File: tb/tb_lfsr_word_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_lfsr_word_sched
// Brief    : Directed self-checking bench for lfsr_word_sched (N_REQ=4, W=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_lfsr_word_sched;

    logic clk;
    logic reset;
    int   n_total;
    int   n_bad;
    logic [27:0] m_lfsr;

    lfsr_word_sched_if #(.N_REQ(4), .W(8)) bus ();

    lfsr_word_sched #(
        .N_REQ        (4),
        .W            (8),
        .DEFAULT_SEED (28'hACE1234)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference LFSR: r=s[27], fb=s[27]^s[24], s<={s[26:0],fb}.
    task automatic model_next(output logic [7:0] w);
        w = '0;
        for (int i = 0; i < 8; i++) begin
            w      = {w[6:0], m_lfsr[27]};
            m_lfsr = {m_lfsr[26:0], m_lfsr[27] ^ m_lfsr[24]};
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after a clock edge; returns in the ack cycle with req dropped.
    task automatic run_req(input int idx, input logic [7:0] expw, input int exp_lat,
                           input int seed_at, input logic [27:0] seed_val, input string tag);
        int   n;
        logic seen;
        bus.req[idx] = 1'b1;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            if (n == seed_at) begin
                bus.seed_i    = seed_val;
                bus.seed_load = 1'b1;
            end else begin
                bus.seed_load = 1'b0;
            end
            tick();
            n++;
            if (n == exp_lat - 8) check({tag, "_gnt"}, 32'(bus.gnt), 32'(1) << idx);
            if (bus.ack) seen = 1'b1;
        end
        bus.seed_load = 1'b0;
        check({tag, "_lat"}, n, exp_lat);
        check({tag, "_word"}, 32'(bus.word_data), 32'(expw));
        check({tag, "_gnt_ack"}, 32'(bus.gnt), 32'(1) << idx);
        bus.req[idx] = 1'b0;
    endtask

    initial begin
        logic [7:0] w;
        int         n;
        int         acks;
        logic       seen;

        n_total       = 0;
        n_bad         = 0;
        reset         = 1'b0;
        bus.req       = '0;
        bus.seed_i    = '0;
        bus.seed_load = 1'b0;
        m_lfsr        = 28'hACE1234;

        repeat (3) tick();
        check("rst_gnt", 32'(bus.gnt), 0);
        check("rst_ack", 32'(bus.ack), 0);
        check("rst_word", 32'(bus.word_data), 0);
        check("rst_busy", 32'(bus.busy), 0);
        reset = 1'b1;
        tick();

        // 1: first word from the default seed is its top byte.
        run_req(0, 8'hAC, 9, -1, '0, "t1");
        tick();

        // 2: seed with ones only in the top nibble.
        bus.seed_i    = 28'hF000000;
        bus.seed_load = 1'b1;
        tick();
        bus.seed_load = 1'b0;
        check("t2_busy_pend", 32'(bus.busy), 1);
        run_req(0, 8'hF0, 11, -1, '0, "t2a");
        tick();
        run_req(0, 8'h00, 9, -1, '0, "t2b");
        tick();

        // 3: zero seed substitutes the default seed.
        bus.seed_i    = '0;
        bus.seed_load = 1'b1;
        tick();
        bus.seed_load = 1'b0;
        run_req(1, 8'hAC, 11, -1, '0, "t3");
        tick();
        check("t3_idle_busy", 32'(bus.busy), 0);

        // 4: all four requesting; fresh reset puts the pointer at 0.
        reset = 1'b0;
        tick();
        reset  = 1'b1;
        m_lfsr = 28'hACE1234;
        tick();
        bus.req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            n    = 0;
            seen = 1'b0;
            while (!seen && n < 40) begin
                tick();
                n++;
                if (bus.ack) seen = 1'b1;
            end
            model_next(w);
            check($sformatf("t4_gap%0d", k), n, (k == 0) ? 9 : 10);
            check($sformatf("t4_gnt%0d", k), 32'(bus.gnt), 32'(1) << k);
            check($sformatf("t4_word%0d", k), 32'(bus.word_data), 32'(w));
            bus.req[k] = 1'b0;
        end
        tick();

        // 5: reseed mid-GATHER leaves the current word on the old stream.
        model_next(w);
        run_req(2, w, 9, 3, 28'hF000000, "t5a");
        run_req(3, 8'hF0, 12, -1, '0, "t5b");
        tick();

        // 6: reset in the fourth GATHER cycle aborts the word.
        bus.req[0] = 1'b1;
        repeat (4) tick();
        check("t6_gnt_pre", 32'(bus.gnt), 1);
        reset      = 1'b0;
        bus.req[0] = 1'b0;
        tick();
        check("t6_gnt", 32'(bus.gnt), 0);
        check("t6_ack", 32'(bus.ack), 0);
        check("t6_busy", 32'(bus.busy), 0);
        check("t6_word", 32'(bus.word_data), 0);
        reset = 1'b1;
        acks  = 0;
        repeat (12) begin
            tick();
            if (bus.ack) acks++;
        end
        check("t6_no_ack", acks, 0);
        run_req(0, 8'hAC, 9, -1, '0, "t6_after");
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_lfsr_word_sched
`default_nettype wire
